fixed_to_float8: RTL and testbench

- Converts a sign-magnitude fixed-point value into the team's 8-bit float format: bit7 sign, [6:4] exponent, [3:0] mantissa, bias 3.
- Decoded value is mantissa * 2^(exp-3), with no hidden bit.
- Sits after the float divider: packed quotient/remainder results in fixed point are re-encoded to float8 for storage or the next operation.
- Normalisation is iterative, one exponent step per cycle, with valid/ready handshakes on both sides.

---
 rtl/fixed_to_float8.sv | 141 ++++++++++++++
 tb/tb_fixed_to_float8.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float8.sv
// fixed_to_float8: re-encodes a sign-magnitude Q(INT_BITS).4 value into the
// 8-bit float format {sign, exp[2:0], mant[3:0]} with bias 3 and no hidden bit
// (value = mant * 2^(exp-3)). Normalisation walks the exponent up by one step
// per cycle, with round-half-up and a sticky bit for the inexact flag.
module fixed_to_float8 #(
   parameter int INT_BITS = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_sign,
   input  logic [INT_BITS+4-1:0]         in_fixed,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [7:0]                    out_float,
   output logic                          out_overflow,
   output logic                          out_inexact,
   output logic                          busy
);

   localparam int FRAC_BITS = 4;
   localparam int W         = INT_BITS + FRAC_BITS;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      DONE
   } state_t;

   state_t         state;
   state_t         state_next;

   logic [W-1:0]   r;
   logic [W-1:0]   r_next;
   logic [2:0]     e;
   logic [2:0]     e_next;
   logic           sticky;
   logic           sticky_next;
   logic           sgn;
   logic           sgn_next;

   logic [7:0]     float_q;
   logic [7:0]     float_next;
   logic           overflow_q;
   logic           overflow_next;
   logic           inexact_q;
   logic           inexact_next;

   // Candidate mantissa at the current exponent: r is in units of 1/16 shifted
   // by e, so dropping one more bit gives units of 2^(e-3); round half up.
   logic [W-1:0]   cand;
   logic           cand_fits;

   assign cand      = (r >> 1) + {{(W-1){1'b0}}, r[0]};
   assign cand_fits = (cand[W-1:4] == '0);

   // Next-state and datapath updates; the result registers only change on the
   // NORM->DONE transition so they stay stable while the consumer stalls.
   always_comb begin
      state_next    = state;
      r_next        = r;
      e_next        = e;
      sticky_next   = sticky;
      sgn_next      = sgn;
      float_next    = float_q;
      overflow_next = overflow_q;
      inexact_next  = inexact_q;

      case (state)
         IDLE: begin
            if (in_valid) begin
               r_next      = in_fixed;
               e_next      = 3'd0;
               sticky_next = 1'b0;
               sgn_next    = in_sign;
               state_next  = NORM;
            end
         end

         NORM: begin
            if (cand_fits) begin
               float_next    = {sgn & (cand[3:0] != 4'd0), e, cand[3:0]};
               overflow_next = 1'b0;
               inexact_next  = sticky | r[0];
               state_next    = DONE;
            end else if (e == 3'd7) begin
               float_next    = {sgn, 3'd7, 4'hF};
               overflow_next = 1'b1;
               inexact_next  = 1'b1;
               state_next    = DONE;
            end else begin
               sticky_next = sticky | r[0];
               r_next      = r >> 1;
               e_next      = e + 3'd1;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         r          <= '0;
         e          <= 3'd0;
         sticky     <= 1'b0;
         sgn        <= 1'b0;
         float_q    <= 8'd0;
         overflow_q <= 1'b0;
         inexact_q  <= 1'b0;
      end else begin
         state      <= state_next;
         r          <= r_next;
         e          <= e_next;
         sticky     <= sticky_next;
         sgn        <= sgn_next;
         float_q    <= float_next;
         overflow_q <= overflow_next;
         inexact_q  <= inexact_next;
      end
   end

   assign in_ready     = (state == IDLE);
   assign out_valid    = (state == DONE);
   assign busy         = (state != IDLE);
   assign out_float    = float_q;
   assign out_overflow = overflow_q;
   assign out_inexact  = inexact_q;

endmodule

// File: tb/tb_fixed_to_float8.sv
// tb_fixed_to_float8: directed vectors with hand-computed float8 results.
// The driver pushes the expected result when it offers an operand; a monitor
// pops and compares whenever a result handshake happens.
module tb_fixed_to_float8;

   localparam int INT_BITS = 8;
   localparam int W        = INT_BITS + 4;

   logic          clock;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic          in_sign;
   logic [W-1:0]  in_fixed;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_float;
   logic          out_overflow;
   logic          out_inexact;
   logic          busy;

   typedef struct {
      logic [7:0] flt;
      logic       ovf;
      logic       inx;
      int         norm;
   } expect_t;

   expect_t sb[$];

   int checks;
   int failures;

   fixed_to_float8 #(.INT_BITS(INT_BITS)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sign      (in_sign),
      .in_fixed     (in_fixed),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_float    (out_float),
      .out_overflow (out_overflow),
      .out_inexact  (out_inexact),
      .busy         (busy)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Offer one operand as soon as the block is ready and record its result.
   task automatic applyStimulus(input logic [W-1:0] fixed, input logic sign,
                                input logic [7:0] flt, input logic ovf,
                                input logic inx, input int norm);
      expect_t x;
      int guard;
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(posedge clock); #1;
         guard++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("[TB] FAIL in_ready timeout: got 0, expected 1");
      end
      x.flt = flt;
      x.ovf = ovf;
      x.inx = inx;
      x.norm = norm;
      sb.push_back(x);
      in_valid = 1'b1;
      in_fixed = fixed;
      in_sign  = sign;
      @(posedge clock); #1;
      in_valid = 1'b0;
      in_fixed = ~fixed;
      in_sign  = ~sign;
   endtask

   // Wait for the scoreboard to drain and the block to return to IDLE.
   task automatic waitIdle();
      int guard;
      guard = 0;
      while ((sb.size() != 0 || !in_ready) && guard < 200) begin
         @(posedge clock); #1;
         guard++;
      end
      if (sb.size() != 0 || !in_ready) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain timeout: got %0d pending, expected 0", sb.size());
      end
   endtask

   // Monitor: measures accept-to-valid latency and scores each result handshake.
   int  cyc;
   int  acceptCycle;
   logic prevValid;
   initial begin
      cyc = 0;
      acceptCycle = 0;
      prevValid = 1'b0;
      forever begin
         @(negedge clock);
         cyc++;
         if (reset) begin
            prevValid = 1'b0;
         end else begin
            if (in_valid && in_ready) begin
               acceptCycle = cyc;
            end
            if (out_valid && !prevValid && sb.size() != 0) begin
               checkOutput("latency", cyc - acceptCycle, sb[0].norm + 1);
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected result: got 0x%0h, expected none", out_float);
               end else begin
                  expect_t x;
                  x = sb.pop_front();
                  checkOutput("out_float", int'(out_float), int'(x.flt));
                  checkOutput("out_overflow", int'(out_overflow), int'(x.ovf));
                  checkOutput("out_inexact", int'(out_inexact), int'(x.inx));
               end
            end
            prevValid = out_valid;
         end
      end
   end

   // Main sequence: reset, directed vectors, back-pressure and mid-flight reset.
   initial begin
      int guard;
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_fixed  = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      checkOutput("reset in_ready", int'(in_ready), 1);
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkOutput("reset out_float", int'(out_float), 0);
      checkOutput("reset out_overflow", int'(out_overflow), 0);
      checkOutput("reset out_inexact", int'(out_inexact), 0);
      checkOutput("reset busy", int'(busy), 0);

      // fixed, sign, float, ovf, inx, NORM cycles
      applyStimulus(12'h048, 1'b0, 8'h29, 1'b0, 1'b0, 3); waitIdle();
      applyStimulus(12'hF00, 1'b1, 8'hFF, 1'b0, 1'b0, 8); waitIdle();
      applyStimulus(12'hFFF, 1'b0, 8'h7F, 1'b1, 1'b1, 8); waitIdle();
      applyStimulus(12'h001, 1'b0, 8'h01, 1'b0, 1'b1, 1); waitIdle();
      applyStimulus(12'h023, 1'b0, 8'h19, 1'b0, 1'b1, 2); waitIdle();
      applyStimulus(12'h000, 1'b1, 8'h00, 1'b0, 1'b0, 1); waitIdle();
      applyStimulus(12'h010, 1'b1, 8'h88, 1'b0, 1'b0, 1); waitIdle();
      applyStimulus(12'h100, 1'b0, 8'h48, 1'b0, 1'b0, 5); waitIdle();
      applyStimulus(12'h01F, 1'b0, 8'h18, 1'b0, 1'b1, 2); waitIdle();

      // Back-pressure: result must hold and new operands must be refused.
      out_ready = 1'b0;
      applyStimulus(12'h048, 1'b0, 8'h29, 1'b0, 1'b0, 3);
      guard = 0;
      while (!out_valid && guard < 50) begin
         @(posedge clock); #1;
         guard++;
      end
      checkOutput("stall out_valid rise", int'(out_valid), 1);
      in_valid = 1'b1;
      in_fixed = 12'h001;
      in_sign  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         checkOutput("stall out_float", int'(out_float), 8'h29);
         checkOutput("stall in_ready", int'(in_ready), 0);
         checkOutput("stall out_valid", int'(out_valid), 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      waitIdle();
      repeat (4) @(posedge clock);
      #1;
      checkOutput("post-stall busy", int'(busy), 0);

      // Reset during the second NORM cycle aborts the operand.
      applyStimulus(12'h048, 1'b0, 8'h29, 1'b0, 1'b0, 3);
      @(posedge clock); #1;
      checkOutput("pre-abort busy", int'(busy), 1);
      reset = 1'b1;
      @(posedge clock); #1;
      checkOutput("abort in_ready", int'(in_ready), 1);
      checkOutput("abort out_valid", int'(out_valid), 0);
      checkOutput("abort busy", int'(busy), 0);
      reset = 1'b0;
      sb.delete();
      applyStimulus(12'h048, 1'b0, 8'h29, 1'b0, 1'b0, 3); waitIdle();

      repeat (3) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
